// File: rtl/tsxb_pkg.sv
// ---------------------------------------------------------------------------
// tsxb_pkg : shared FCI mux selects and bridge state encoding.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tsxb_pkg;

   localparam logic [1:0] FCI_ZAL = 2'd0;
   localparam logic [1:0] FCI_ZAH = 2'd1;
   localparam logic [1:0] FCI_ZD  = 2'd2;
   localparam logic [1:0] FCI_ZC  = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_AL   = 4'd1,
      S_AH   = 4'd2,
      S_DT   = 4'd3,
      S_REQ  = 4'd4,
      S_RW   = 4'd5,
      S_TO   = 4'd6,
      S_DRV  = 4'd7,
      S_TF   = 4'd8,
      S_END  = 4'd9
   } state_t;

endpackage

`default_nettype wire

// File: rtl/tsxb_sync2.sv
// ---------------------------------------------------------------------------
// tsxb_sync2 : two-flop synchronizer for active-low strobes, resets to 1.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tsxb_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

`default_nettype wire

// File: rtl/tsxb_fci_bridge.sv
// ---------------------------------------------------------------------------
// tsxb_fci_bridge : rebuilds ZX-BUS cycles from the multiplexed FCI link and
// drives claimed read data back toward the CPLD. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tsxb_fci_bridge
   import tsxb_pkg::*;
#(
   parameter int SETTLE     = 2,
   parameter int RD_TIMEOUT = 16
) (
   input  logic        CLK_IN,
   input  logic        RST_N,
   input  logic        FRD_N,
   input  logic        FWR_N,
   input  logic        FMRQ_N,
   input  logic        FIORQ_N,
   input  logic [7:0]  FCI_IN,
   output logic [7:0]  FCI_OUT,
   output logic        FCI_OE,
   output logic [1:0]  FCI_S,
   output logic        FDIR,
   output logic        req_valid,
   output logic        req_wr,
   output logic        req_io,
   output logic [15:0] req_addr,
   output logic [7:0]  req_data,
   input  logic        rd_ack,
   input  logic        rd_hit,
   input  logic [7:0]  rd_data
);

   localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

   logic frd_s, fwr_s, fmrq_s, fiorq_s;
   logic rd, wr, mrq, iorq, active, phase_done;

   state_t           state, state_nx;
   logic [3:0]       cnt, cnt_nx;
   logic [TMO_W-1:0] tmo, tmo_nx;
   logic [1:0]       fci_s_nx;
   logic             fdir_nx, oe_nx, valid_nx, wr_nx, io_nx;
   logic [7:0]       out_nx, data_nx;
   logic [15:0]      addr_nx;

   tsxb_sync2 u_sync_rd   (.clk(CLK_IN), .rst_n(RST_N), .d(FRD_N),   .q(frd_s));
   tsxb_sync2 u_sync_wr   (.clk(CLK_IN), .rst_n(RST_N), .d(FWR_N),   .q(fwr_s));
   tsxb_sync2 u_sync_mrq  (.clk(CLK_IN), .rst_n(RST_N), .d(FMRQ_N),  .q(fmrq_s));
   tsxb_sync2 u_sync_iorq (.clk(CLK_IN), .rst_n(RST_N), .d(FIORQ_N), .q(fiorq_s));

   assign rd         = ~frd_s;
   assign wr         = ~fwr_s;
   assign mrq        = ~fmrq_s;
   assign iorq       = ~fiorq_s;
   assign active     = (mrq | iorq) & (rd | wr);
   assign phase_done = (cnt == 4'(SETTLE));

   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         state     <= S_IDLE;
         cnt       <= '0;
         tmo       <= '0;
         FCI_S     <= FCI_ZAL;
         FDIR      <= 1'b1;
         FCI_OE    <= 1'b0;
         FCI_OUT   <= '0;
         req_valid <= 1'b0;
         req_wr    <= 1'b0;
         req_io    <= 1'b0;
         req_addr  <= '0;
         req_data  <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         tmo       <= tmo_nx;
         FCI_S     <= fci_s_nx;
         FDIR      <= fdir_nx;
         FCI_OE    <= oe_nx;
         FCI_OUT   <= out_nx;
         req_valid <= valid_nx;
         req_wr    <= wr_nx;
         req_io    <= io_nx;
         req_addr  <= addr_nx;
         req_data  <= data_nx;
      end
   end

   // Direction and enable only ever move one per cycle, so the link is never
   // driven from both ends.
   always_comb begin
      state_nx = state;
      cnt_nx   = '0;
      tmo_nx   = '0;
      fci_s_nx = FCI_S;
      fdir_nx  = FDIR;
      oe_nx    = FCI_OE;
      out_nx   = FCI_OUT;
      valid_nx = 1'b0;
      wr_nx    = req_wr;
      io_nx    = req_io;
      addr_nx  = req_addr;
      data_nx  = req_data;

      case (state)
         S_IDLE: begin
            if (active) begin
               io_nx    = iorq;
               wr_nx    = wr;
               data_nx  = '0;
               fci_s_nx = FCI_ZAL;
               state_nx = S_AL;
            end
         end
         S_AL: begin
            if (!active) begin
               state_nx = S_END;
            end else if (phase_done) begin
               addr_nx[7:0] = FCI_IN;
               fci_s_nx     = FCI_ZAH;
               state_nx     = S_AH;
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         S_AH: begin
            if (!active) begin
               state_nx = S_END;
            end else if (phase_done) begin
               addr_nx[15:8] = FCI_IN;
               if (req_wr) begin
                  fci_s_nx = FCI_ZD;
                  state_nx = S_DT;
               end else begin
                  state_nx = S_REQ;
               end
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         S_DT: begin
            if (!active) begin
               state_nx = S_END;
            end else if (phase_done) begin
               data_nx  = FCI_IN;
               state_nx = S_REQ;
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         S_REQ: begin
            valid_nx = 1'b1;
            state_nx = req_wr ? S_END : S_RW;
         end
         S_RW: begin
            if (!active) begin
               state_nx = S_END;
            end else if (rd_ack && rd_hit) begin
               out_nx   = rd_data;
               fdir_nx  = 1'b0;
               state_nx = S_TO;
            end else if (rd_ack || (tmo == TMO_W'(RD_TIMEOUT - 1))) begin
               state_nx = S_END;
            end else begin
               tmo_nx = tmo + TMO_W'(1);
            end
         end
         S_TO: begin
            oe_nx    = 1'b1;
            state_nx = S_DRV;
         end
         S_DRV: begin
            if (!rd) begin
               oe_nx    = 1'b0;
               state_nx = S_TF;
            end
         end
         S_TF: begin
            fdir_nx  = 1'b1;
            state_nx = S_END;
         end
         S_END: begin
            if (!(mrq | iorq) && !(rd | wr)) begin
               fci_s_nx = FCI_ZAL;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_tsxb_fci_bridge.sv
// Scoreboard bench for tsxb_fci_bridge: a CPLD mux model feeds FCI_IN, expected
// requests are queued at stimulus time and compared on each req_valid.
`timescale 1ns/1ps

module tb_tsxb_fci_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frd_n, fwr_n, fmrq_n, fiorq_n;
   logic [7:0]  fci_in, fci_out;
   logic        fci_oe, fdir;
   logic [1:0]  fci_s;
   logic        req_valid, req_wr, req_io;
   logic [15:0] req_addr;
   logic [7:0]  req_data;
   logic        rd_ack, rd_hit;
   logic [7:0]  rd_data;
   logic [15:0] bus_addr;
   logic [7:0]  bus_data;

   always #10 clk = ~clk;

   assign fci_in = (fci_s == 2'd0) ? bus_addr[7:0] :
                   (fci_s == 2'd1) ? bus_addr[15:8] : bus_data;

   tsxb_fci_bridge dut (
      .CLK_IN(clk), .RST_N(rst_n),
      .FRD_N(frd_n), .FWR_N(fwr_n), .FMRQ_N(fmrq_n), .FIORQ_N(fiorq_n),
      .FCI_IN(fci_in), .FCI_OUT(fci_out), .FCI_OE(fci_oe), .FCI_S(fci_s), .FDIR(fdir),
      .req_valid(req_valid), .req_wr(req_wr), .req_io(req_io),
      .req_addr(req_addr), .req_data(req_data),
      .rd_ack(rd_ack), .rd_hit(rd_hit), .rd_data(rd_data)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct packed {
      logic        wr;
      logic        io;
      logic [15:0] addr;
      logic [7:0]  data;
   } req_t;

   req_t exp_q[$];
   int   req_cnt   = 0;
   int   dirlo_cnt = 0;
   int   oe_cnt    = 0;
   logic prev_fdir = 1'b1;
   logic prev_oe   = 1'b0;
   bit   mon_en    = 1'b0;

   always @(negedge clk) begin
      req_t e;
      if (req_valid) begin
         req_cnt++;
         if (exp_q.size() == 0) begin
            chk("req_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("req_wr",   {31'd0, req_wr}, {31'd0, e.wr});
            chk("req_io",   {31'd0, req_io}, {31'd0, e.io});
            chk("req_addr", {16'd0, req_addr}, {16'd0, e.addr});
            chk("req_data", {24'd0, req_data}, {24'd0, e.data});
         end
      end
      if (!fdir)  dirlo_cnt++;
      if (fci_oe) oe_cnt++;
      if (mon_en && fci_oe && !prev_oe) chk("oe_rise_needs_fdir_low", {31'd0, prev_fdir}, 32'd0);
      if (mon_en && fdir && !prev_fdir) chk("fdir_rise_needs_oe_low", {31'd0, prev_oe}, 32'd0);
      prev_fdir = fdir;
      prev_oe   = fci_oe;
   end

   task automatic start_cycle(input logic io, input logic wr, input logic [15:0] a,
                              input logic [7:0] d, input logic expect_req);
      req_t e;
      bus_addr = a;
      bus_data = d;
      if (expect_req) begin
         e.wr = wr; e.io = io; e.addr = a; e.data = wr ? d : 8'h00;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      if (io) fiorq_n = 1'b0; else fmrq_n = 1'b0;
      if (wr) fwr_n = 1'b0;   else frd_n = 1'b0;
   endtask

   task automatic end_cycle();
      @(posedge clk); #1;
      frd_n = 1'b1; fwr_n = 1'b1; fmrq_n = 1'b1; fiorq_n = 1'b1;
      repeat (6) @(posedge clk);
   endtask

   // Counts rising edges from strobe assertion until req_valid; -1 if none.
   task automatic wait_req(input int budget, output int lat);
      int n;
      bit got;
      n = 0; got = 1'b0;
      while (!got && n < budget) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (req_valid) got = 1'b1;
      end
      lat = got ? n : -1;
   endtask

   task automatic ack(input logic hit, input logic [7:0] d);
      @(posedge clk); #1;
      rd_ack = 1'b1; rd_hit = hit; rd_data = d;
      @(posedge clk); #1;
      rd_ack = 1'b0; rd_hit = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, r0, d0, o0;
      rst_n = 1'b0;
      frd_n = 1'b1; fwr_n = 1'b1; fmrq_n = 1'b1; fiorq_n = 1'b1;
      rd_ack = 1'b0; rd_hit = 1'b0; rd_data = 8'h00;
      bus_addr = 16'h0000; bus_data = 8'h00;
      #25;
      chk("rst_ctl", {25'd0, fdir, fci_oe, fci_s, req_valid, req_wr, req_io},
          {25'd0, 7'b1000000});
      chk("rst_addr", {16'd0, req_addr}, 32'd0);
      chk("rst_data", {16'd0, req_data, fci_out}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      mon_en = 1'b1;

      // Memory write
      r0 = req_cnt; d0 = dirlo_cnt;
      start_cycle(1'b0, 1'b1, 16'h5AC3, 8'hE7, 1'b1);
      wait_req(30, lat);
      chk("wr_latency", lat, 13);
      end_cycle();
      chk("wr_req_count", req_cnt - r0, 1);
      chk("wr_fdir_stays_high", dirlo_cnt - d0, 0);

      // IO read, claimed
      r0 = req_cnt;
      start_cycle(1'b1, 1'b0, 16'h00FE, 8'h00, 1'b1);
      wait_req(30, lat);
      chk("rd_latency", lat, 10);
      ack(1'b1, 8'h1F);
      chk("rd_fdir_low", {31'd0, fdir}, 32'd0);
      chk("rd_oe_not_yet", {31'd0, fci_oe}, 32'd0);
      @(posedge clk); #1;
      chk("rd_oe_on", {31'd0, fci_oe}, 32'd1);
      chk("rd_out", {24'd0, fci_out}, 32'h1F);
      repeat (4) @(posedge clk); #1;
      chk("rd_hold", {23'd0, fci_oe, fci_out}, {23'd0, 1'b1, 8'h1F});
      frd_n = 1'b1; fiorq_n = 1'b1;
      lat = 0;
      while (fci_oe && lat < 10) begin
         @(posedge clk); #1; lat++;
      end
      chk("rd_oe_released", {31'd0, fci_oe}, 32'd0);
      chk("rd_fdir_after_oe", {31'd0, fdir}, 32'd0);
      @(posedge clk); #1;
      chk("rd_fdir_restored", {31'd0, fdir}, 32'd1);
      repeat (6) @(posedge clk);
      chk("rd_req_count", req_cnt - r0, 1);

      // IO read, not claimed
      r0 = req_cnt; d0 = dirlo_cnt; o0 = oe_cnt;
      start_cycle(1'b1, 1'b0, 16'h00FF, 8'h00, 1'b1);
      wait_req(30, lat);
      chk("miss_latency", lat, 10);
      ack(1'b0, 8'h99);
      repeat (4) @(posedge clk);
      end_cycle();
      chk("miss_req_count", req_cnt - r0, 1);
      chk("miss_no_fdir", dirlo_cnt - d0, 0);
      chk("miss_no_oe", oe_cnt - o0, 0);

      // Read with no answer; a late ack must be ignored after the timeout
      r0 = req_cnt; d0 = dirlo_cnt; o0 = oe_cnt;
      start_cycle(1'b0, 1'b0, 16'h1234, 8'h00, 1'b1);
      wait_req(30, lat);
      chk("tmo_latency", lat, 10);
      repeat (20) @(posedge clk);
      ack(1'b1, 8'hAA);
      repeat (4) @(posedge clk);
      end_cycle();
      chk("tmo_req_count", req_cnt - r0, 1);
      chk("tmo_no_fdir", dirlo_cnt - d0, 0);
      chk("tmo_no_oe", oe_cnt - o0, 0);

      // Next cycle after timeout decodes normally
      r0 = req_cnt;
      start_cycle(1'b0, 1'b1, 16'h8001, 8'h3C, 1'b1);
      wait_req(30, lat);
      chk("post_tmo_latency", lat, 13);
      end_cycle();
      chk("post_tmo_req_count", req_cnt - r0, 1);

      // Strobes released while the high address byte is being sampled
      r0 = req_cnt;
      start_cycle(1'b0, 1'b0, 16'h4321, 8'h00, 1'b0);
      repeat (5) @(posedge clk); #1;
      frd_n = 1'b1; fmrq_n = 1'b1;
      repeat (20) @(posedge clk);
      chk("abort_no_req", req_cnt - r0, 0);
      chk("abort_fci_s", {30'd0, fci_s}, 32'd0);

      r0 = req_cnt;
      start_cycle(1'b1, 1'b1, 16'h0C0D, 8'h5A, 1'b1);
      wait_req(30, lat);
      chk("post_abort_latency", lat, 13);
      end_cycle();
      chk("post_abort_req_count", req_cnt - r0, 1);

      // Reset pulsed while driving
      start_cycle(1'b1, 1'b0, 16'h7FFD, 8'h00, 1'b1);
      wait_req(30, lat);
      ack(1'b1, 8'h55);
      @(posedge clk); #1;
      chk("rst_pre_drive", {31'd0, fci_oe}, 32'd1);
      mon_en = 1'b0;
      #4 rst_n = 1'b0;
      #1;
      chk("rst_async_oe", {31'd0, fci_oe}, 32'd0);
      chk("rst_async_fdir", {31'd0, fdir}, 32'd1);
      chk("rst_async_out", {24'd0, fci_out}, 32'd0);
      chk("rst_async_addr", {16'd0, req_addr}, 32'd0);
      frd_n = 1'b1; fiorq_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk); #1;
      chk("post_rst_ctl", {25'd0, fdir, fci_oe, fci_s, req_valid, req_wr, req_io},
          {25'd0, 7'b1000000});
      chk("post_rst_data", {8'd0, req_addr, fci_out}, 32'd0);
      mon_en = 1'b1;

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
